// File: rtl/rs_dispatch_scheduler_pkg.sv
// Shared types for the reservation-station dispatch scheduler: instruction
// payload, station classes, FSM states and the opcode-to-station mapping.
package rs_dispatch_scheduler_pkg;

   localparam int unsigned RS_CLASS_COUNT = 3;
   localparam int unsigned INSTR_W        = 32;
   localparam int unsigned OPCODE_W       = 7;

   typedef logic [OPCODE_W-1:0] opcode_t;

   localparam opcode_t OPC_LOAD   = 7'b0000011;
   localparam opcode_t OPC_STORE  = 7'b0100011;
   localparam opcode_t OPC_BRANCH = 7'b1100011;
   localparam opcode_t OPC_JAL    = 7'b1101111;
   localparam opcode_t OPC_JALR   = 7'b1100111;
   localparam opcode_t OPC_OP     = 7'b0110011;
   localparam opcode_t OPC_OP_IMM = 7'b0010011;
   localparam opcode_t OPC_LUI    = 7'b0110111;
   localparam opcode_t OPC_AUIPC  = 7'b0010111;
   localparam opcode_t OPC_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [INSTR_W-OPCODE_W-1:0] fields;
      opcode_t                     opcode;
   } instruction_t;

   typedef enum logic [1:0] {
      RS_ALU = 2'd0,
      RS_LSU = 2'd1,
      RS_BRU = 2'd2
   } rs_class_t;

   typedef enum logic {
      DISP_PASS = 1'b0,
      DISP_HOLD = 1'b1
   } dispatch_state_t;

   // Unknown opcodes fall back to the ALU station.
   function automatic rs_class_t classify(input instruction_t instr);
      rs_class_t cls;
      case (instr.opcode)
         OPC_LOAD, OPC_STORE:           cls = RS_LSU;
         OPC_BRANCH, OPC_JAL, OPC_JALR: cls = RS_BRU;
         default:                       cls = RS_ALU;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/rs_dispatch_scheduler_credit_counter.sv
// Free-entry credit counter for one reservation station: takes 0/1/2 per
// cycle, returns 0/1, saturates at full and reloads to full on flush.
module rs_credit_counter #(
   parameter int unsigned NUM_ENTRIES = 8,
   parameter int unsigned CREDIT_W    = $clog2(NUM_ENTRIES) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   input  logic [1:0]          dec_i,
   input  logic                inc_i,
   output logic [CREDIT_W-1:0] credit_o
);

   localparam int unsigned SUM_W = CREDIT_W + 1;

   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [SUM_W-1:0]    avail;

   always_comb begin
      credit_d = credit_q;
      avail    = SUM_W'(credit_q) + SUM_W'(inc_i);
      if (flush_i) begin
         credit_d = CREDIT_W'(NUM_ENTRIES);
      end else if (SUM_W'(dec_i) > avail) begin
         credit_d = '0;
      end else if (avail - SUM_W'(dec_i) > SUM_W'(NUM_ENTRIES)) begin
         credit_d = CREDIT_W'(NUM_ENTRIES);
      end else begin
         credit_d = CREDIT_W'(avail - SUM_W'(dec_i));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) credit_q <= CREDIT_W'(NUM_ENTRIES);
      else      credit_q <= credit_d;
   end

   assign credit_o = credit_q;

   // Dispatch may only spend credits that were already registered.
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
      !flush_i |-> (SUM_W'(dec_i) <= SUM_W'(credit_q)));
   a_saturate: assert property (@(posedge clk) disable iff (!rst)
      credit_q <= CREDIT_W'(NUM_ENTRIES));

endmodule

// File: rtl/rs_dispatch_scheduler.sv
// In-order two-wide dispatch into ALU/LSU/BRU reservation stations with
// credit back-pressure and a one-entry split hold. Perf counters: DISPATCH_PERF_CNT_EN.
module rs_dispatch_scheduler
   import rs_dispatch_scheduler_pkg::*;
#(
   parameter int unsigned NUM_RS_ENTRIES = 8,
   parameter int unsigned ROB_WIDTH      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  instruction_t         in_instr_0,
   input  instruction_t         in_instr_1,
   input  logic [ROB_WIDTH-1:0] in_rob_id_0,
   input  logic [ROB_WIDTH-1:0] in_rob_id_1,
   input  logic                 in_valid_0,
   input  logic                 in_valid_1,
   output logic                 in_ready,
   input  logic                 alu_issue_valid,
   input  logic                 lsu_issue_valid,
   input  logic                 bru_issue_valid,
   output instruction_t         out_instr_0,
   output instruction_t         out_instr_1,
   output logic [ROB_WIDTH-1:0] out_rob_id_0,
   output logic [ROB_WIDTH-1:0] out_rob_id_1,
   output logic                 alu_valid_0,
   output logic                 alu_valid_1,
   output logic                 lsu_valid_0,
   output logic                 lsu_valid_1,
   output logic                 bru_valid_0,
   output logic                 bru_valid_1,
   output logic [31:0]          stall_cycles,
   output logic [31:0]          hold_events
);

   localparam int unsigned CREDIT_W = $clog2(NUM_RS_ENTRIES) + 1;

   dispatch_state_t state_q, state_d;
   instruction_t    hold_instr_q, hold_instr_d;
   logic [ROB_WIDTH-1:0] hold_rob_q, hold_rob_d;
   instruction_t    out_instr_0_q, out_instr_0_d, out_instr_1_q, out_instr_1_d;
   logic [ROB_WIDTH-1:0] out_rob_0_q, out_rob_0_d, out_rob_1_q, out_rob_1_d;
   logic [RS_CLASS_COUNT-1:0] v0_q, v0_d, v1_q, v1_d, ret;
   logic [RS_CLASS_COUNT-1:0][CREDIT_W-1:0] credit;
   logic [RS_CLASS_COUNT-1:0][1:0]          dec;
   rs_class_t cls0, cls1, clsh;
   logic      fit0, fit1, fith;

   assign ret = {bru_issue_valid, lsu_issue_valid, alu_issue_valid};

   for (genvar g = 0; g < RS_CLASS_COUNT; g++) begin : g_credit
      rs_credit_counter #(
         .NUM_ENTRIES (NUM_RS_ENTRIES),
         .CREDIT_W    (CREDIT_W)
      ) u_credit (
         .clk      (clk),
         .rst      (rst),
         .flush_i  (flush),
         .dec_i    (dec[g]),
         .inc_i    (ret[g]),
         .credit_o (credit[g])
      );
   end

   // Fit decisions look only at registered credits.
   always_comb begin
      cls0 = classify(in_instr_0);
      cls1 = classify(in_instr_1);
      clsh = classify(hold_instr_q);
      fit0 = credit[cls0] != '0;
      fit1 = (cls1 == cls0) ? (credit[cls1] >= CREDIT_W'(2)) : (credit[cls1] != '0);
      fith = credit[clsh] != '0;
   end

   always_comb begin
      state_d       = state_q;
      hold_instr_d  = hold_instr_q;
      hold_rob_d    = hold_rob_q;
      out_instr_0_d = out_instr_0_q;
      out_instr_1_d = out_instr_1_q;
      out_rob_0_d   = out_rob_0_q;
      out_rob_1_d   = out_rob_1_q;
      v0_d          = '0;
      v1_d          = '0;
      dec           = '0;
      in_ready      = 1'b0;
      if (flush) begin
         state_d = DISP_PASS;
      end else begin
         case (state_q)
            DISP_PASS: begin
               in_ready = !in_valid_0 || fit0;
               if (in_valid_0 && fit0) begin
                  v0_d[cls0]    = 1'b1;
                  out_instr_0_d = in_instr_0;
                  out_rob_0_d   = in_rob_id_0;
                  dec[cls0]     = dec[cls0] + 2'd1;
                  if (in_valid_1) begin
                     if (fit1) begin
                        v1_d[cls1]    = 1'b1;
                        out_instr_1_d = in_instr_1;
                        out_rob_1_d   = in_rob_id_1;
                        dec[cls1]     = dec[cls1] + 2'd1;
                     end else begin
                        hold_instr_d = in_instr_1;
                        hold_rob_d   = in_rob_id_1;
                        state_d      = DISP_HOLD;
                     end
                  end
               end
            end
            DISP_HOLD: begin
               if (fith) begin
                  v0_d[clsh]    = 1'b1;
                  out_instr_0_d = hold_instr_q;
                  out_rob_0_d   = hold_rob_q;
                  dec[clsh]     = 2'd1;
                  state_d       = DISP_PASS;
               end
            end
            default: state_d = DISP_PASS;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= DISP_PASS;
         hold_instr_q  <= '0;
         hold_rob_q    <= '0;
         out_instr_0_q <= '0;
         out_instr_1_q <= '0;
         out_rob_0_q   <= '0;
         out_rob_1_q   <= '0;
         v0_q          <= '0;
         v1_q          <= '0;
      end else begin
         state_q       <= state_d;
         hold_instr_q  <= hold_instr_d;
         hold_rob_q    <= hold_rob_d;
         out_instr_0_q <= out_instr_0_d;
         out_instr_1_q <= out_instr_1_d;
         out_rob_0_q   <= out_rob_0_d;
         out_rob_1_q   <= out_rob_1_d;
         v0_q          <= v0_d;
         v1_q          <= v1_d;
      end
   end

   assign out_instr_0  = out_instr_0_q;
   assign out_instr_1  = out_instr_1_q;
   assign out_rob_id_0 = out_rob_0_q;
   assign out_rob_id_1 = out_rob_1_q;
   assign alu_valid_0  = v0_q[RS_ALU];
   assign lsu_valid_0  = v0_q[RS_LSU];
   assign bru_valid_0  = v0_q[RS_BRU];
   assign alu_valid_1  = v1_q[RS_ALU];
   assign lsu_valid_1  = v1_q[RS_LSU];
   assign bru_valid_1  = v1_q[RS_BRU];

`ifdef DISPATCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, hold_cnt_q;
   logic        hold_evt;

   assign hold_evt = (state_q == DISP_PASS) && (state_d == DISP_HOLD);

   // Free-running wrap-around counters, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         hold_cnt_q  <= '0;
      end else begin
         if (in_valid_0 && !in_ready && !flush) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (hold_evt)                          hold_cnt_q  <= hold_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign hold_events  = hold_cnt_q;
`else
   assign stall_cycles = '0;
   assign hold_events  = '0;
`endif

endmodule

// File: tb/tb_rs_dispatch_scheduler.sv
// Scoreboard bench for rs_dispatch_scheduler: directed pairs push expected
// dispatches, a negedge monitor pops and compares whenever a station valid fires.
module tb_rs_dispatch_scheduler;
   import rs_dispatch_scheduler_pkg::*;

   localparam int unsigned ROB_W = 4;
   localparam logic [5:0] V_ALU0 = 6'b100000, V_LSU0 = 6'b010000, V_BRU0 = 6'b001000;
   localparam logic [5:0] V_ALU1 = 6'b000100, V_LSU1 = 6'b000010, V_BRU1 = 6'b000001;

   logic clk, rst, flush;
   instruction_t in_instr_0, in_instr_1, out_instr_0, out_instr_1;
   logic [ROB_W-1:0] in_rob_id_0, in_rob_id_1, out_rob_id_0, out_rob_id_1;
   logic in_valid_0, in_valid_1, in_ready;
   logic alu_issue_valid, lsu_issue_valid, bru_issue_valid;
   logic alu_valid_0, alu_valid_1, lsu_valid_0, lsu_valid_1, bru_valid_0, bru_valid_1;
   logic [31:0] stall_cycles, hold_events;

   rs_dispatch_scheduler #(.NUM_RS_ENTRIES(8), .ROB_WIDTH(ROB_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_instr_0(in_instr_0), .in_instr_1(in_instr_1),
      .in_rob_id_0(in_rob_id_0), .in_rob_id_1(in_rob_id_1),
      .in_valid_0(in_valid_0), .in_valid_1(in_valid_1), .in_ready(in_ready),
      .alu_issue_valid(alu_issue_valid), .lsu_issue_valid(lsu_issue_valid),
      .bru_issue_valid(bru_issue_valid),
      .out_instr_0(out_instr_0), .out_instr_1(out_instr_1),
      .out_rob_id_0(out_rob_id_0), .out_rob_id_1(out_rob_id_1),
      .alu_valid_0(alu_valid_0), .alu_valid_1(alu_valid_1),
      .lsu_valid_0(lsu_valid_0), .lsu_valid_1(lsu_valid_1),
      .bru_valid_0(bru_valid_0), .bru_valid_1(bru_valid_1),
      .stall_cycles(stall_cycles), .hold_events(hold_events)
   );

   typedef struct packed {
      logic [5:0]   v;
      instruction_t i0;
      instruction_t i1;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   logic [5:0] mon_act;
   int n_checks = 0;
   int n_fail   = 0;
   instruction_t nil;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic instruction_t mk(input opcode_t op, input int unsigned tag);
      instruction_t r;
      r.fields      = '0;
      r.fields[7:0] = 8'(tag);
      r.opcode      = op;
      return r;
   endfunction

   function automatic logic [ROB_W-1:0] rob_of(input instruction_t i);
      return i.fields[ROB_W-1:0];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [5:0] v, input instruction_t i0, input instruction_t i1);
      exp_t e;
      e.v  = v;
      e.i0 = i0;
      e.i1 = i1;
      exp_q.push_back(e);
   endtask

   // One cycle: drive at posedge+1, check in_ready once settled, advance.
   task automatic cyc(input logic v0, input instruction_t i0, input logic v1,
                      input instruction_t i1, input logic [2:0] ret, input logic fl,
                      input logic exp_rdy, input string nm);
      in_valid_0 = v0;  in_instr_0 = i0;  in_rob_id_0 = rob_of(i0);
      in_valid_1 = v1;  in_instr_1 = i1;  in_rob_id_1 = rob_of(i1);
      {bru_issue_valid, lsu_issue_valid, alu_issue_valid} = ret;
      flush = fl;
      #1;
      chk(nm, 64'(in_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [2:0] ret, input logic fl, input logic exp_rdy, input string nm);
      cyc(1'b0, nil, 1'b0, nil, ret, fl, exp_rdy, nm);
   endtask

   // Monitor: every presented dispatch must match the oldest expectation.
   always @(negedge clk) begin
      if (rst) begin
         mon_act = {alu_valid_0, lsu_valid_0, bru_valid_0, alu_valid_1, lsu_valid_1, bru_valid_1};
         if (mon_act != 6'b0) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_dispatch: valids=%b instr0=0x%0h, expected no dispatch",
                        mon_act, out_instr_0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("mon_valids", 64'(mon_act), 64'(mon_e.v));
               chk("mon_instr0", 64'(out_instr_0), 64'(mon_e.i0));
               chk("mon_rob0", 64'(out_rob_id_0), 64'(rob_of(mon_e.i0)));
               if (mon_e.v[2:0] != 3'b0) begin
                  chk("mon_instr1", 64'(out_instr_1), 64'(mon_e.i1));
                  chk("mon_rob1", 64'(out_rob_id_1), 64'(rob_of(mon_e.i1)));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      instruction_t a, b, x, y;
      nil = '0;
      rst = 1'b0; flush = 1'b0;
      in_valid_0 = 1'b0; in_valid_1 = 1'b0;
      in_instr_0 = '0; in_instr_1 = '0; in_rob_id_0 = '0; in_rob_id_1 = '0;
      alu_issue_valid = 1'b0; lsu_issue_valid = 1'b0; bru_issue_valid = 1'b0;
      #12;
      chk("rst_valids", 64'({alu_valid_0, lsu_valid_0, bru_valid_0, alu_valid_1, lsu_valid_1, bru_valid_1}), 64'(0));
      chk("rst_out_instr0", 64'(out_instr_0), 64'(0));
      chk("rst_out_rob0", 64'(out_rob_id_0), 64'(0));
      chk("rst_out_instr1", 64'(out_instr_1), 64'(0));
      rst = 1'b1;
      #1;
      chk("rst_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;

      // OP + LOAD pair dispatches to two stations at once.
      a = mk(OPC_OP, 1); b = mk(OPC_LOAD, 2);
      push(V_ALU0 | V_LSU1, a, b);
      cyc(1, a, 1, b, 3'b000, 0, 1, "t1_pair_ready");
      idle(3'b011, 0, 1, "t1_return_idle");
      idle(3'b000, 1, 0, "t1_flush_ready_low");

      // ALU drains after eight singles; a return unblocks the ninth a cycle later.
      for (int i = 0; i < 8; i++) begin
         a = mk(OPC_OP, 16 + i);
         push(V_ALU0, a, nil);
         cyc(1, a, 0, nil, 3'b000, 0, 1, $sformatf("t2_alu_fit_%0d", i));
      end
      a = mk(OPC_OP, 30);
      cyc(1, a, 0, nil, 3'b000, 0, 0, "t2_ninth_stall");
      cyc(1, a, 0, nil, 3'b001, 0, 0, "t2_stall_on_return");
      push(V_ALU0, a, nil);
      cyc(1, a, 0, nil, 3'b000, 0, 1, "t2_ninth_after_return");
      b = mk(OPC_LOAD, 31);
      push(V_LSU0, b, nil);
      cyc(1, b, 0, nil, 3'b000, 0, 1, "t2_lsu_independent");
      idle(3'b000, 1, 0, "t2_flush");

      // ALU credit 1 with OP + OP: split, hold, release after a return.
      for (int i = 0; i < 7; i++) begin
         a = mk(OPC_OP, 32 + i);
         push(V_ALU0, a, nil);
         cyc(1, a, 0, nil, 3'b000, 0, 1, $sformatf("t3_fill_%0d", i));
      end
      x = mk(OPC_OP, 40); y = mk(OPC_OP, 41);
      push(V_ALU0, x, nil);
      cyc(1, x, 1, y, 3'b000, 0, 1, "t3_split_ready");
      idle(3'b000, 0, 0, "t3_hold_ready_low");
      idle(3'b001, 0, 0, "t3_hold_return");
      push(V_ALU0, y, nil);
      idle(3'b000, 0, 0, "t3_hold_dispatch");
      idle(3'b000, 0, 1, "t3_back_in_pass");
      a = mk(OPC_OP, 42);
      cyc(1, a, 0, nil, 3'b000, 0, 0, "t3_alu_empty");
      idle(3'b000, 1, 0, "t3_flush");

      // Bring credits to ALU 3 / LSU 5 / BRU 0.
      a = mk(OPC_OP, 50); b = mk(OPC_OP, 51); push(V_ALU0 | V_ALU1, a, b);
      cyc(1, a, 1, b, 3'b000, 0, 1, "t5_alu_pair_a");
      a = mk(OPC_OP, 52); b = mk(OPC_OP, 53); push(V_ALU0 | V_ALU1, a, b);
      cyc(1, a, 1, b, 3'b000, 0, 1, "t5_alu_pair_b");
      a = mk(OPC_OP, 54); b = mk(OPC_LOAD, 55); push(V_ALU0 | V_LSU1, a, b);
      cyc(1, a, 1, b, 3'b000, 0, 1, "t5_mixed_pair");
      a = mk(OPC_STORE, 56); b = mk(OPC_LOAD, 57); push(V_LSU0 | V_LSU1, a, b);
      cyc(1, a, 1, b, 3'b000, 0, 1, "t5_lsu_pair");
      for (int k = 0; k < 4; k++) begin
         a = mk(OPC_BRANCH, 60 + 2 * k); b = mk(OPC_JAL, 61 + 2 * k);
         push(V_BRU0 | V_BRU1, a, b);
         cyc(1, a, 1, b, 3'b000, 0, 1, $sformatf("t5_bru_pair_%0d", k));
      end
      a = mk(OPC_BRANCH, 70); b = mk(OPC_OP, 71);
      cyc(1, a, 1, b, 3'b000, 0, 0, "t5_bru_empty_stall_a");
      cyc(1, a, 1, b, 3'b000, 0, 0, "t5_bru_empty_stall_b");
      a = mk(OPC_JALR, 72); b = mk(OPC_BRANCH, 73);
      cyc(1, a, 1, b, 3'b100, 0, 0, "t5_stall_return");
      push(V_BRU0, a, nil);
      cyc(1, a, 1, b, 3'b000, 0, 1, "t5_split_same_station");

      // Flush in HOLD wins over a held instruction that would now fit.
      idle(3'b100, 0, 0, "t6_hold_return");
      idle(3'b011, 1, 0, "t6_flush_in_hold");
      idle(3'b000, 0, 1, "t6_post_flush_ready");
      for (int k = 0; k < 4; k++) begin
         a = mk(OPC_BRANCH, 80 + 2 * k); b = mk(OPC_JALR, 81 + 2 * k);
         push(V_BRU0 | V_BRU1, a, b);
         cyc(1, a, 1, b, 3'b000, 0, 1, $sformatf("t6_bru_full_%0d", k));
      end
      a = mk(OPC_BRANCH, 90);
      cyc(1, a, 0, nil, 3'b000, 0, 0, "t6_bru_full_exact");
      for (int k = 0; k < 4; k++) begin
         a = mk(OPC_LUI, 100 + 2 * k); b = mk(OPC_SYSTEM, 101 + 2 * k);
         push(V_ALU0 | V_ALU1, a, b);
         cyc(1, a, 1, b, 3'b000, 0, 1, $sformatf("t6_alu_full_%0d", k));
      end
      a = mk(7'b1111111, 108);
      cyc(1, a, 0, nil, 3'b000, 0, 0, "t6_alu_full_exact");
      for (int k = 0; k < 4; k++) begin
         a = mk(OPC_LOAD, 110 + 2 * k); b = mk(OPC_STORE, 111 + 2 * k);
         push(V_LSU0 | V_LSU1, a, b);
         cyc(1, a, 1, b, 3'b000, 0, 1, $sformatf("t6_lsu_full_%0d", k));
      end
      a = mk(OPC_LOAD, 118);
      cyc(1, a, 0, nil, 3'b000, 0, 0, "t6_lsu_full_exact");

      // Reset while holding discards the held instruction.
      idle(3'b001, 0, 1, "t7_return");
      x = mk(OPC_AUIPC, 120); y = mk(OPC_OP_IMM, 121);
      push(V_ALU0, x, nil);
      cyc(1, x, 1, y, 3'b000, 0, 1, "t7_split");
      in_valid_0 = 1'b0; in_valid_1 = 1'b0; alu_issue_valid = 1'b0;
      @(negedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("t7_ready_after_reset", 64'(in_ready), 64'(1));
      @(posedge clk); #1;

      // Perf scenario: exactly five stalled cycles and one split.
      a = mk(OPC_OP, 130); push(V_ALU0, a, nil);
      cyc(1, a, 0, nil, 3'b000, 0, 1, "p_single");
      for (int k = 0; k < 3; k++) begin
         a = mk(OPC_OP, 131 + 2 * k); b = mk(OPC_OP, 132 + 2 * k);
         push(V_ALU0 | V_ALU1, a, b);
         cyc(1, a, 1, b, 3'b000, 0, 1, $sformatf("p_pair_%0d", k));
      end
      a = mk(OPC_OP, 137); push(V_ALU0, a, nil);
      cyc(1, a, 0, nil, 3'b000, 0, 1, "p_last_credit");
      a = mk(OPC_OP, 140);
      for (int k = 0; k < 5; k++)
         cyc(1, a, 0, nil, (k == 4) ? 3'b001 : 3'b000, 0, 0, $sformatf("p_stall_%0d", k));
      x = mk(OPC_OP, 141); y = mk(OPC_OP, 142);
      push(V_ALU0, x, nil);
      cyc(1, x, 1, y, 3'b000, 0, 1, "p_split");
      idle(3'b001, 0, 0, "p_hold_return");
      push(V_ALU0, y, nil);
      idle(3'b000, 0, 0, "p_hold_dispatch");
      idle(3'b000, 0, 1, "p_pass");
`ifdef DISPATCH_PERF_CNT_EN
      chk("perf_stall_cycles", 64'(stall_cycles), 64'(5));
      chk("perf_hold_events", 64'(hold_events), 64'(1));
`else
      chk("perf_stall_tied", 64'(stall_cycles), 64'(0));
      chk("perf_hold_tied", 64'(hold_events), 64'(0));
`endif
      idle(3'b000, 0, 1, "end_idle_a");
      idle(3'b000, 0, 1, "end_idle_b");
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
